// File: rtl/mcu_bus_arbiter.sv
// Round-robin arbiter sharing the mcu_logic register bus between NREQ requesters.
// One strobe per transaction, fixed read latency, one-cycle ack to the winner.
module mcu_bus_arbiter #(
   parameter int NREQ   = 2,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int RDLAT  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          req_wr,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*DATA_W-1:0]   req_wrdata,
   output logic [NREQ-1:0]          ack,
   output logic [DATA_W-1:0]        rd_data,
   output logic [ADDR_W-1:0]        baddr,
   output logic [DATA_W-1:0]        bwrdata,
   output logic                     bwr,
   output logic                     bstrobe,
   input  logic [DATA_W-1:0]        brddata,
   output logic                     busy,
   output logic [2:0]               owner
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_STROBE,
      S_WAIT,
      S_DONE
   } state_t;

   localparam logic [3:0] LP_CNT_INIT = 4'(RDLAT - 1);

   state_t              r_state;
   logic [2:0]          r_ptr;
   logic [3:0]          r_cnt;

   logic                w_any;
   logic [2:0]          w_win;
   logic [2:0]          w_next;
   logic                w_wr;
   logic [ADDR_W-1:0]   w_addr;
   logic [DATA_W-1:0]   w_wdata;
   logic [NREQ-1:0]     w_own_oh;

   // Scan offsets farthest-first so the requester nearest ptr wins last.
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         for (int j = 0; j < NREQ; j++) begin
            if (req[j] && (j == (int'(r_ptr) + k) % NREQ)) begin
               w_any = 1'b1;
               w_win = 3'(j);
            end
         end
      end
   end

   always_comb begin
      w_next  = 3'((int'(w_win) + 1) % NREQ);
      w_wr    = 1'b0;
      w_addr  = '0;
      w_wdata = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (w_win == 3'(j)) begin
            w_wr    = req_wr[j];
            w_addr  = req_addr[j*ADDR_W +: ADDR_W];
            w_wdata = req_wrdata[j*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      w_own_oh = '0;
      for (int j = 0; j < NREQ; j++) begin
         w_own_oh[j] = (owner == 3'(j));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_cnt   <= '0;
         ack     <= '0;
         rd_data <= '0;
         baddr   <= '0;
         bwrdata <= '0;
         bwr     <= 1'b0;
         bstrobe <= 1'b0;
         busy    <= 1'b0;
         owner   <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_state <= S_STROBE;
                  baddr   <= w_addr;
                  bwrdata <= w_wdata;
                  bwr     <= w_wr;
                  owner   <= w_win;
                  r_ptr   <= w_next;
                  bstrobe <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            S_STROBE: begin
               bstrobe <= 1'b0;
               if (bwr) begin
                  r_state <= S_DONE;
                  ack     <= w_own_oh;
               end else begin
                  r_state <= S_WAIT;
                  r_cnt   <= LP_CNT_INIT;
               end
            end
            S_WAIT: begin
               if (r_cnt == 4'd0) begin
                  rd_data <= brddata;
                  ack     <= w_own_oh;
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_DONE: begin
               ack     <= '0;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mcu_bus_arbiter.md
Name: mcu_bus_arbiter

Overview:
Shares the single mcu_logic register bus (baddr/bwrdata/bwr/bstrobe/brddata) between NREQ requesters, for example the host interface and an on-board link-sync sequencer.
- Arbitration is round-robin.
- Each transaction is one bstrobe pulse, followed by a fixed read-latency wait for reads.
- Each transaction ends with a one-cycle acknowledge to the winning requester.
- Sits between the requesters and mcu_logic; all bus outputs are registered.

Parameters:
NREQ, 2, number of requesters (2..8)
ADDR_W, 16, bus address width
DATA_W, 16, bus data width
RDLAT, 2, cycles from bstrobe to brddata valid (1..15; 0 illegal)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
req  in  NREQ  per-requester transaction request; level, held until ack
req_wr  in  NREQ  per-requester 1=write, 0=read
req_addr  in  NREQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W]
req_wrdata  in  NREQ*DATA_W  packed write data; same packing
ack  out  NREQ  one-cycle done pulse to the winning requester
rd_data  out  DATA_W  read result, valid while ack is high; held until the next read completes
baddr  out  ADDR_W  bus address to mcu_logic
bwrdata  out  DATA_W  bus write data
bwr  out  1  bus write flag
bstrobe  out  1  one-cycle bus strobe
brddata  in  DATA_W  bus read data from mcu_logic
busy  out  1  high in every state except IDLE
owner  out  3  index of the current or most recent winner

Behaviour:
- Reset (async, immediate): state=IDLE; ack, rd_data, baddr, bwrdata, bwr, bstrobe, busy, owner all 0; round-robin pointer ptr=0. Reset mid-transaction aborts it: bstrobe drops immediately and no ack is issued.
- States and transitions:
  - IDLE: if any req bit is high, choose winner w = first i with req[i]=1, scanning ptr, ptr+1, ... mod NREQ.
  - IDLE -> STROBE at the next edge: latch baddr, bwrdata, bwr from w; set owner=w, bstrobe=1, ptr=(w+1) mod NREQ.
  - STROBE (1 cycle): bstrobe=1; baddr/bwrdata/bwr stay stable through the whole transaction.
    - Write: -> DONE.
    - Read: -> WAIT with a counter loaded to RDLAT-1.
  - WAIT: counter decrements each cycle. When counter=0: rd_data<=brddata, -> DONE. WAIT lasts exactly RDLAT cycles.
  - DONE (1 cycle): ack[owner]=1, all other ack bits 0; no arbitration in this cycle -> IDLE.
- Timing, with req first seen in IDLE at cycle t:
  - bstrobe high in cycle t+1.
  - Write: ack in t+2, IDLE in t+3.
  - Read: brddata is sampled at the end of cycle t+1+RDLAT, ack in t+2+RDLAT.
- Requester contract: drop req (or present the next request) on the edge where ack is sampled high. A req still high in IDLE after DONE is a new transaction.
- The winner's req/addr/data are sampled only at IDLE->STROBE. Later changes, including req dropping mid-transaction, do not affect the current transaction, and its ack is still issued.
- Simultaneous requests: round-robin guarantees each active requester is served within NREQ transactions.
- Only one ack bit is ever high, and never outside DONE. bstrobe is high only in STROBE.
- busy=1 in STROBE, WAIT and DONE.

Test Plan:
- Single write, NREQ=2: req[0]=1, wr=1, addr=0x0012, wrdata=0xBEEF -> one bstrobe cycle with baddr=0x0012, bwrdata=0xBEEF, bwr=1; ack=2'b01 exactly one cycle later; owner=0.
- Single read, RDLAT=2: req[1]=1, wr=0, addr=0x0003, brddata model returns 0x1234 two cycles after strobe -> ack=2'b10 at strobe+3, rd_data=0x1234, bwr=0.
- Simultaneous: req=2'b11 from reset -> requester 0 served first, then 1. With both requesters re-requesting after each ack, the grant order alternates 0,1,0,1 over 8 transactions.
- Requester 1 alone re-requests continuously -> served every transaction: write period 3 cycles, read period RDLAT+3 cycles.
- Reset asserted during WAIT -> bstrobe, ack and busy go to 0 immediately; after release, a pending req starts a fresh transaction with ptr=0.
- Requester 0 drops req during WAIT -> transaction completes, ack[0] still pulses, rd_data still updates.
